clkdiv_scheduler: RTL and testbench

Runtime-programmable divider controller that turns the single fast system clock into NUM_CH independent divided clocks, each with a one-cycle tick enable. It replaces hard-coded divider counters (I2C/SPI/ILA/input-sample rates).
- Accepts divisor changes through a valid/ready config port and applies them only at period boundaries, so outputs never glitch.
- Sequences per-channel start and stop without runt pulses.
- Sits beside the differential clock buffer; feeds the I2C/SPI FSMs and sampling logic.

---
 rtl/clkdiv_pkg.sv | 12 +
 rtl/clkdiv_channel.sv | 137 +++++++++++++
 rtl/clkdiv_scheduler.sv | 70 +++++++
 tb/tb_clkdiv_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and default sizing for the clock divider scheduler.
package clkdiv_pkg;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 24;
  localparam int DEF_RST_DIV = 10;

  typedef enum logic [1:0] {
    CH_OFF      = 2'd0,
    CH_RUN      = 2'd1,
    CH_STOPPING = 2'd2
  } ch_state_t;
endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: OFF/RUN/STOPPING FSM, half-period counter and a
// pending-divisor register that is applied only at full-period boundaries.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_start,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend,
  output ch_state_t        state
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             tc;
  logic             do_apply;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_OFF;
      cnt_q   <= '0;
      div_q   <= CNT_W'(RST_DIV);
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pdiv_d   = pdiv_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    do_apply = 1'b0;
    tc       = (cnt_q == div_q);

    case (state_q)
      CH_OFF: begin
        cnt_d    = '0;
        clk_d    = 1'b0;
        do_apply = 1'b1;
        if (en) state_d = CH_RUN;
      end
      CH_RUN: begin
        // A low phase can be cut short safely; a high phase must complete.
        if (!en && !clk_q) begin
          state_d = CH_OFF;
          cnt_d   = '0;
        end else begin
          if (!en) state_d = CH_STOPPING;
          if (tc) begin
            cnt_d  = '0;
            clk_d  = !clk_q;
            tick_d = !clk_q;
            if (clk_q) begin
              do_apply = 1'b1;
              if (!en) state_d = CH_OFF;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CH_STOPPING: begin
        if (en) state_d = CH_RUN;
        if (tc) begin
          cnt_d    = '0;
          clk_d    = 1'b0;
          do_apply = 1'b1;
          if (!en) state_d = CH_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = CH_OFF;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    // Phase alignment overrides any coincident terminal count.
    if (sync_start && state_q != CH_OFF) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      do_apply = 1'b1;
      state_d  = (state_q == CH_RUN && en) ? CH_RUN : CH_OFF;
    end

    if (do_apply && pend_q) begin
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end

    // cfg_we only arrives while pend_q is clear, so it never races an apply.
    if (cfg_we) begin
      if (state_q == CH_OFF) begin
        div_d = cfg_div;
      end else begin
        pdiv_d = cfg_div;
        pend_d = 1'b1;
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;
  assign state   = state_q;

endmodule

// File: rtl/clkdiv_scheduler.sv
// NUM_CH runtime-programmable glitch-free clock dividers behind one config port.
// Optional CLKDIV_SYNC_START_EN adds a sync_start input that phase-aligns all running channels.
module clkdiv_scheduler
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH  = DEF_NUM_CH,
  parameter int  CNT_W   = DEF_CNT_W,
  parameter int  RST_DIV = DEF_RST_DIV,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef CLKDIV_SYNC_START_EN
  input  logic              sync_start,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] cfg_we;
  logic              sync_int;
  ch_state_t         ch_state [NUM_CH];

`ifdef CLKDIV_SYNC_START_EN
  assign sync_int = sync_start;
`else
  assign sync_int = 1'b0;
`endif

  // Valid/ready: a write transfers on any cycle with cfg_valid && cfg_ready;
  // ready drops only while the addressed channel holds an unapplied divisor,
  // and an address with no channel behind it is always ready and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (cfg_ch == CH_W'(i));
      if (sel[i] && pend[i]) cfg_ready = 1'b0;
    end
  end

  assign cfg_we = sel & {NUM_CH{cfg_valid && cfg_ready}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W  (CNT_W),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[g]),
      .sync_start(sync_int),
      .cfg_we    (cfg_we[g]),
      .cfg_div   (cfg_div),
      .clk_out   (clk_out[g]),
      .tick      (tick[g]),
      .pend      (pend[g]),
      .state     (ch_state[g])
    );
    assign busy[g] = (ch_state[g] != CH_OFF);
  end

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// Self-checking bench for clkdiv_scheduler; expected waveforms come from
// closed-form period arithmetic relative to the cycle a channel was enabled.
module tb_clkdiv_scheduler;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 24;
  localparam int RST_DIV = 10;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
`ifdef CLKDIV_SYNC_START_EN
  logic              sync_start;
`endif

  int n_cmp;
  int n_bad;

  clkdiv_scheduler #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .RST_DIV(RST_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef CLKDIV_SYNC_START_EN
    .sync_start(sync_start),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLKDIV_SYNC_START_EN
    sync_start = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
  endtask

  // ---------------- driver ----------------
  task automatic cfg_write(input int ch, input int div);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = CNT_W'(div);
    step();
    cfg_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Enable set during cycle 0: divided clock is low for d+1 cycles starting at
  // cycle 1, then alternates d+1-cycle phases.
  function automatic logic exp_clk(int n, int d);
    if (n < 1) return 1'b0;
    return (((n - 1) / (d + 1)) % 2) == 1;
  endfunction

  function automatic logic exp_tick(int n, int d);
    return (n >= 1) && (((n - 1) % (d + 1)) == 0) && exp_clk(n, d);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] ec, et;
    do_reset();
    if ({clk_out, tick, busy} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs got clk_out=%b tick=%b busy=%b exp all 0", clk_out, tick, busy);
    end
    n_cmp++;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_ch = 2'(c);
      #1;
      if (cfg_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ready ch%0d got %b exp 1", c, cfg_ready);
      end
      n_cmp++;
    end
    cfg_ch = '0;
    en = 4'b0001;
    for (int n = 1; n <= 70; n++) begin
      step();
      ec = {3'b000, exp_clk(n, RST_DIV)};
      et = {3'b000, exp_tick(n, RST_DIV)};
      if (clk_out !== ec || tick !== et || busy !== 4'b0001) begin
        n_bad++;
        $display("FAIL default_run n=%0d got %b/%b/%b exp %b/%b/0001", n, clk_out, tick, busy, ec, et);
      end
      n_cmp++;
    end
  endtask

  task automatic test_random_div();
    logic [3:0] ec, et, eb;
    int c, d;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      c = $urandom_range(0, NUM_CH - 1);
      d = (it == 0) ? 0 : $urandom_range(0, 15);
      cfg_ch = 2'(c);
      #1;
      if (cfg_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL off_write_ready ch%0d got %b exp 1", c, cfg_ready);
      end
      n_cmp++;
      cfg_write(c, d);
      en = '0;
      en[c] = 1'b1;
      for (int n = 1; n <= 4 * (d + 1) + 3; n++) begin
        step();
        ec = '0; et = '0; eb = '0;
        ec[c] = exp_clk(n, d);
        et[c] = exp_tick(n, d);
        eb[c] = 1'b1;
        if (clk_out !== ec || tick !== et || busy !== eb) begin
          n_bad++;
          $display("FAIL random_div ch%0d d=%0d n=%0d got %b/%b/%b exp %b/%b/%b",
                   c, d, n, clk_out, tick, busy, ec, et, eb);
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_reconfig();
    logic ec, et, er;
    int w, b, m;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      w = (it == 0) ? 22 : $urandom_range(12, 21);
      // A write landing on the boundary cycle waits a whole further period.
      b = (w == 22) ? 45 : 23;
      cfg_ch = 2'd0;
      en = 4'b0001;
      for (int n = 1; n <= b + 30; n++) begin
        step();
        if (n < b) begin
          ec = exp_clk(n, RST_DIV);
          et = exp_tick(n, RST_DIV);
        end else begin
          m  = n - b;
          ec = ((m / 5) % 2) == 1;
          et = ((m % 5) == 0) && ec;
        end
        er = (n >= w + 1 && n <= b - 1) ? 1'b0 : 1'b1;
        if (clk_out[0] !== ec || tick[0] !== et || busy[0] !== 1'b1 || cfg_ready !== er) begin
          n_bad++;
          $display("FAIL reconfig w=%0d n=%0d got clk=%b tick=%b busy=%b rdy=%b exp %b %b 1 %b",
                   w, n, clk_out[0], tick[0], busy[0], cfg_ready, ec, et, er);
        end
        n_cmp++;
        cfg_valid = (n == w);
        cfg_div   = CNT_W'(4);
      end
      cfg_valid = 1'b0;
    end
  endtask

  task automatic test_stop();
    logic ec, et, eb;
    int s, stop_c;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      s = (it == 0) ? 15 : $urandom_range(1, 44);
      stop_c = exp_clk(s, RST_DIV) ? (((s - 1) / (RST_DIV + 1)) + 1) * (RST_DIV + 1) : s;
      en = 4'b0001;
      for (int n = 1; n <= stop_c + 15; n++) begin
        step();
        ec = (n <= stop_c) ? exp_clk(n, RST_DIV) : 1'b0;
        et = (n <= stop_c) ? exp_tick(n, RST_DIV) : 1'b0;
        eb = (n <= stop_c);
        if (clk_out[0] !== ec || tick[0] !== et || busy[0] !== eb) begin
          n_bad++;
          $display("FAIL stop s=%0d n=%0d got %b/%b/%b exp %b/%b/%b",
                   s, n, clk_out[0], tick[0], busy[0], ec, et, eb);
        end
        n_cmp++;
        if (n == s) en[0] = 1'b0;
      end
    end
  endtask

  task automatic test_restart();
    logic [3:0] ec, et;
    int d, s;
    do_reset();
    d = $urandom_range(2, 12);
    s = $urandom_range(d + 2, 2 * d);
    cfg_write(1, d);
    en = 4'b0010;
    for (int n = 1; n <= 5 * (d + 1) + 2; n++) begin
      step();
      ec = {2'b00, exp_clk(n, d), 1'b0};
      et = {2'b00, exp_tick(n, d), 1'b0};
      if (clk_out !== ec || tick !== et || busy !== 4'b0010) begin
        n_bad++;
        $display("FAIL restart d=%0d s=%0d n=%0d got %b/%b/%b exp %b/%b/0010",
                 d, s, n, clk_out, tick, busy, ec, et);
      end
      n_cmp++;
      if (n == s) en[1] = 1'b0;
      if (n == s + 2) en[1] = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ec, et;
    int r;
    do_reset();
    cfg_write(0, 3);
    en = 4'b1111;
    r = $urandom_range(8, 21);
    for (int n = 1; n <= r; n++) begin
      step();
      cfg_valid = (n == 5);
      cfg_ch    = 2'd1;
      cfg_div   = CNT_W'(2);
    end
    cfg_valid = 1'b0;
    if (cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_before_reset got rdy=%b exp 0", cfg_ready);
    end
    n_cmp++;
    #3 rst = 1'b1;
    #1;
    if ({clk_out, tick, busy} !== 12'h000 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset got %b/%b/%b rdy=%b exp 0000/0000/0000 rdy=1",
               clk_out, tick, busy, cfg_ready);
    end
    n_cmp++;
    en = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    en = 4'b0011;
    for (int n = 1; n <= 50; n++) begin
      step();
      ec = {2'b00, exp_clk(n, RST_DIV), exp_clk(n, RST_DIV)};
      et = {2'b00, exp_tick(n, RST_DIV), exp_tick(n, RST_DIV)};
      if (clk_out !== ec || tick !== et || busy !== 4'b0011) begin
        n_bad++;
        $display("FAIL after_reset n=%0d got %b/%b/%b exp %b/%b/0011", n, clk_out, tick, busy, ec, et);
      end
      n_cmp++;
    end
  endtask

`ifdef CLKDIV_SYNC_START_EN
  task automatic test_sync();
    logic [3:0] ec, et;
    int k;
    do_reset();
    cfg_write(0, 4);
    cfg_write(1, 9);
    en = 4'b0001;
    for (int n = 1; n <= 90; n++) begin
      step();
      if (n == 3) en = 4'b0011;
      sync_start = (n == 30);
      if (n > 30) begin
        k  = n - 31;
        ec = {2'b00, ((k / 10) % 2) == 1, ((k / 5) % 2) == 1};
        et = {2'b00, (k % 10 == 0) && ((k / 10) % 2 == 1), (k % 5 == 0) && ((k / 5) % 2 == 1)};
        if (clk_out !== ec || tick !== et || busy !== 4'b0011) begin
          n_bad++;
          $display("FAIL sync n=%0d got %b/%b/%b exp %b/%b/0011", n, clk_out, tick, busy, ec, et);
        end
        n_cmp++;
      end
    end
    sync_start = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_random_div();
    test_reconfig();
    test_stop();
    test_restart();
    test_reset_mid();
`ifdef CLKDIV_SYNC_START_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
